// File: rtl/flag_register.sv
// flag_register
// Condition-code register feeding the branch flag selector mux.
// Captures Z/N/C/V/LT/LE from the ALU under a per-bit mask. It also
// supports a parallel load and a one-deep shadow copy (save/restore)
// used around interrupt or call entry.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset, overrides every other input
//   alu_result   ALU output for the current cycle (WIDTH bits)
//   alu_carry    ALU carry-out (not-borrow on subtract)
//   alu_ovf      ALU signed overflow
//   update       capture freshly computed flags, filtered by mask
//   mask         per-bit write enable for update (1 = bit written)
//   save         copy current flags into the shadow register
//   restore      copy shadow register into flags (consumes the shadow)
//   load         parallel load of flags from load_data
//   load_data    value written by load
//   flags        registered condition codes {LE,LT,V,C,N,Z}
//   saved_flags  shadow register contents
//   saved_valid  shadow register holds a saved value
//   restore_err  one-cycle pulse after a restore with an empty shadow
module flag_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  input  logic             update,
  input  logic [5:0]       mask,
  input  logic             save,
  input  logic             restore,
  input  logic             load,
  input  logic [5:0]       load_data,
  output logic [5:0]       flags,
  output logic [5:0]       saved_flags,
  output logic             saved_valid,
  output logic             restore_err
);

  // LT and LE are derived from the fresh N/V/Z of this ALU result,
  // never from the stored flag bits.
  function automatic logic [5:0] compute_flags(
    input logic [WIDTH-1:0] res,
    input logic             carry,
    input logic             ovf
  );
    logic z;
    logic n;
    logic lt;
    z  = (res == {WIDTH{1'b0}});
    n  = res[WIDTH-1];
    lt = n ^ ovf;
    return {lt | z, lt, ovf, carry, n, z};
  endfunction

  logic [5:0] flags_r;
  logic [5:0] saved_flags_r;
  logic       saved_valid_r;
  logic       restore_err_r;

  logic [5:0] computed_s;
  logic [5:0] flags_next_s;
  logic [5:0] saved_flags_next_s;
  logic       saved_valid_next_s;
  logic       restore_ok_s;
  logic       restore_bad_s;

  assign computed_s    = compute_flags(alu_result, alu_carry, alu_ovf);
  assign restore_ok_s  = restore & saved_valid_r;
  assign restore_bad_s = restore & ~saved_valid_r;

  // Next-state selection: load > valid restore > masked update > hold.
  always_comb begin
    flags_next_s       = flags_r;
    saved_flags_next_s = saved_flags_r;
    saved_valid_next_s = saved_valid_r;

    if (load) begin
      flags_next_s = load_data;
    end else if (restore_ok_s) begin
      flags_next_s = saved_flags_r;
    end else if (update) begin
      flags_next_s = (computed_s & mask) | (flags_r & ~mask);
    end else begin
      flags_next_s = flags_r;
    end

    // Save always captures pre-edge flags; combined with a valid restore
    // this forms a swap and the shadow stays valid. A restore that loses
    // to load still consumes the shadow.
    if (save) begin
      saved_flags_next_s = flags_r;
      saved_valid_next_s = 1'b1;
    end else if (restore_ok_s) begin
      saved_flags_next_s = saved_flags_r;
      saved_valid_next_s = 1'b0;
    end else begin
      saved_flags_next_s = saved_flags_r;
      saved_valid_next_s = saved_valid_r;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_r       <= 6'b000000;
      saved_flags_r <= 6'b000000;
      saved_valid_r <= 1'b0;
      restore_err_r <= 1'b0;
    end else begin
      flags_r       <= flags_next_s;
      saved_flags_r <= saved_flags_next_s;
      saved_valid_r <= saved_valid_next_s;
      restore_err_r <= restore_bad_s;
    end
  end

  assign flags       = flags_r;
  assign saved_flags = saved_flags_r;
  assign saved_valid = saved_valid_r;
  assign restore_err = restore_err_r;

endmodule

// File: tb/tb_flag_register.sv
// Self-checking bench for flag_register (WIDTH=8): a directed vector table,
// a few hand-written multi-cycle sequences and a randomized run against a
// behavioural model.
module tb_flag_register;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_ovf;
  logic             update;
  logic [5:0]       mask;
  logic             save;
  logic             restore;
  logic             load;
  logic [5:0]       load_data;
  logic [5:0]       flags;
  logic [5:0]       saved_flags;
  logic             saved_valid;
  logic             restore_err;

  int n_cmp;
  int n_bad;

  flag_register #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_ovf(alu_ovf), .update(update), .mask(mask), .save(save),
    .restore(restore), .load(load), .load_data(load_data), .flags(flags),
    .saved_flags(saved_flags), .saved_valid(saved_valid),
    .restore_err(restore_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       update;
    logic [5:0] mask;
    logic [7:0] res;
    logic       carry;
    logic       ovf;
    logic       save;
    logic       restore;
    logic       load;
    logic [5:0] ld;
    logic [5:0] e_flags;
    logic [5:0] e_saved;
    logic       e_valid;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state
  int m_flags, m_saved, m_valid, m_err;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic up, input logic [5:0] mk,
                       input logic [7:0] res, input logic c, input logic v,
                       input logic sv, input logic rs, input logic ld,
                       input logic [5:0] ldd);
    rst = r; update = up; mask = mk; alu_result = res; alu_carry = c;
    alu_ovf = v; save = sv; restore = rs; load = ld; load_data = ldd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic up, input logic [5:0] mk,
                     input logic [7:0] res, input logic c, input logic v,
                     input logic sv, input logic rs, input logic ld,
                     input logic [5:0] ldd, input logic [5:0] ef,
                     input logic [5:0] es, input logic ev, input logic ee);
    vec_t t;
    t.rst = r; t.update = up; t.mask = mk; t.res = res; t.carry = c;
    t.ovf = v; t.save = sv; t.restore = rs; t.load = ld; t.ld = ldd;
    t.e_flags = ef; t.e_saved = es; t.e_valid = ev; t.e_err = ee;
    vecs.push_back(t);
  endtask

  // Reference model: flags from the arithmetic meaning of the result.
  task automatic model_step();
    int comp[6];
    int nf, ns, nv, ne, z, n, c, v;
    if (rst) begin
      m_flags = 0; m_saved = 0; m_valid = 0; m_err = 0;
      return;
    end
    z = (int'(alu_result) == 0) ? 1 : 0;
    n = (int'(alu_result) >= (1 << (WIDTH - 1))) ? 1 : 0;
    c = int'(alu_carry);
    v = int'(alu_ovf);
    comp[0] = z; comp[1] = n; comp[2] = c; comp[3] = v;
    comp[4] = (n != v) ? 1 : 0;
    comp[5] = ((n != v) || z == 1) ? 1 : 0;
    nf = m_flags;
    if (load) nf = int'(load_data);
    else if (restore && m_valid == 1) nf = m_saved;
    else if (update) begin
      nf = 0;
      for (int i = 0; i < 6; i++)
        nf += (mask[i] ? comp[i] : ((m_flags >> i) & 1)) << i;
    end
    ns = save ? m_flags : m_saved;
    nv = save ? 1 : (restore ? 0 : m_valid);
    ne = (restore && m_valid == 0) ? 1 : 0;
    m_flags = nf; m_saved = ns; m_valid = nv; m_err = ne;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    rst = 1'b1;

    //  rst up mask  res   c  v  sv rs ld ldd    flags  saved  val err
    add(1, 1, 6'h3F, 8'h00, 1, 0, 0, 0, 0, 6'h00, 6'h00, 6'h00, 0, 0);
    add(1, 1, 6'h3F, 8'h00, 1, 0, 0, 0, 0, 6'h00, 6'h00, 6'h00, 0, 0);
    add(0, 1, 6'h3F, 8'h00, 1, 0, 0, 0, 0, 6'h00, 6'h25, 6'h00, 0, 0);
    add(0, 1, 6'h3F, 8'h80, 0, 1, 0, 0, 0, 6'h00, 6'h0A, 6'h00, 0, 0);
    add(0, 1, 6'h3F, 8'h00, 1, 0, 0, 0, 0, 6'h00, 6'h25, 6'h00, 0, 0);
    add(0, 1, 6'h04, 8'h05, 0, 0, 0, 0, 0, 6'h00, 6'h21, 6'h00, 0, 0);
    add(0, 1, 6'h00, 8'h05, 0, 0, 0, 0, 0, 6'h00, 6'h21, 6'h00, 0, 0);
    add(0, 1, 6'h3F, 8'h00, 1, 0, 0, 0, 0, 6'h00, 6'h25, 6'h00, 0, 0);
    add(0, 0, 6'h00, 8'h00, 0, 0, 1, 0, 0, 6'h00, 6'h25, 6'h25, 1, 0);
    add(0, 1, 6'h3F, 8'h80, 0, 1, 0, 0, 0, 6'h00, 6'h0A, 6'h25, 1, 0);
    add(0, 0, 6'h00, 8'h00, 0, 0, 0, 1, 0, 6'h00, 6'h25, 6'h25, 0, 0);
    add(0, 0, 6'h00, 8'h00, 0, 0, 0, 1, 0, 6'h00, 6'h25, 6'h25, 0, 1);
    add(0, 0, 6'h00, 8'h00, 0, 0, 0, 0, 0, 6'h00, 6'h25, 6'h25, 0, 0);
    add(0, 1, 6'h3F, 8'h00, 1, 0, 0, 0, 1, 6'h12, 6'h12, 6'h25, 0, 0);
    add(0, 0, 6'h00, 8'h00, 0, 0, 1, 0, 0, 6'h00, 6'h12, 6'h12, 1, 0);
    add(0, 1, 6'h3F, 8'h80, 0, 1, 0, 0, 0, 6'h00, 6'h0A, 6'h12, 1, 0);
    add(0, 0, 6'h00, 8'h00, 0, 0, 1, 1, 0, 6'h00, 6'h12, 6'h0A, 1, 0);
    add(0, 0, 6'h00, 8'h00, 0, 0, 1, 1, 0, 6'h00, 6'h0A, 6'h12, 1, 0);
    add(0, 0, 6'h00, 8'h00, 0, 0, 0, 1, 1, 6'h3F, 6'h3F, 6'h12, 0, 0);
    add(0, 1, 6'h3F, 8'h00, 1, 0, 1, 1, 0, 6'h00, 6'h25, 6'h3F, 1, 1);
    add(1, 1, 6'h3F, 8'h00, 1, 0, 1, 1, 1, 6'h15, 6'h00, 6'h00, 0, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].update, vecs[k].mask, vecs[k].res,
            vecs[k].carry, vecs[k].ovf, vecs[k].save, vecs[k].restore,
            vecs[k].load, vecs[k].ld);
      tick();
      chk($sformatf("vec%0d.flags", k), int'(flags), int'(vecs[k].e_flags));
      chk($sformatf("vec%0d.saved", k), int'(saved_flags), int'(vecs[k].e_saved));
      chk($sformatf("vec%0d.valid", k), int'(saved_valid), int'(vecs[k].e_valid));
      chk($sformatf("vec%0d.err", k), int'(restore_err), int'(vecs[k].e_err));
    end

    // No combinational path: a new update request must not show before the edge.
    idle();
    tick();
    drive(1'b0, 1'b1, 6'h3F, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00);
    #2;
    chk("no_comb_path", int'(flags), 0);
    tick();
    chk("registered_update", int'(flags), 32'h0A);

    // Reset in the middle of save/restore activity clears everything.
    drive(1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00);
    tick();
    chk("pre_rst_valid", int'(saved_valid), 1);
    drive(1'b1, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00);
    tick();
    chk("rst_mid.flags", int'(flags), 0);
    chk("rst_mid.saved", int'(saved_flags), 0);
    chk("rst_mid.valid", int'(saved_valid), 0);

    // Erroneous restore followed by a second erroneous restore: two pulses,
    // then low again.
    drive(1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00);
    tick();
    chk("err_pulse1", int'(restore_err), 1);
    tick();
    chk("err_pulse2", int'(restore_err), 1);
    idle();
    tick();
    chk("err_clear", int'(restore_err), 0);

    // Randomized run against the behavioural model, starting from reset.
    drive(1'b1, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) begin
        rst        = ($urandom_range(0, 39) == 0);
        update     = $urandom_range(0, 1);
        mask       = 6'($urandom);
        alu_result = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
        alu_carry  = $urandom_range(0, 1);
        alu_ovf    = $urandom_range(0, 1);
        save       = ($urandom_range(0, 3) == 0);
        restore    = ($urandom_range(0, 3) == 0);
        load       = ($urandom_range(0, 7) == 0);
        load_data  = 6'($urandom);
      end
      model_step();
      tick();
      chk($sformatf("rnd%0d.flags", cyc), int'(flags), m_flags);
      chk($sformatf("rnd%0d.saved", cyc), int'(saved_flags), m_saved);
      chk($sformatf("rnd%0d.valid", cyc), int'(saved_valid), m_valid);
      chk($sformatf("rnd%0d.err", cyc), int'(restore_err), m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
